// File: rtl/fir_frame_pkg.sv
// rtl/fir_frame_pkg.sv - shared types, width helpers and round/saturate for fir_frame_engine
// Contents: acc_w/scale_s width helpers, round_sat scaler, writer state enum.
package fir_frame_pkg;

    typedef enum logic {
        FILL = 1'b0,
        DROP = 1'b1
    } wr_state_t;

    // Full-precision accumulator width: product width plus growth for TAPS terms.
    function automatic int acc_w(input int din_w, input int coef_w, input int taps);
        return din_w + coef_w + $clog2(taps);
    endfunction

    // Right shift that brings the accumulator's binary point onto the output's.
    function automatic int scale_s(input int din_frac, input int coef_frac, input int dout_frac);
        return din_frac + coef_frac - dout_frac;
    endfunction

    // Optional round-half-up, arithmetic shift (truncates toward -inf), then clamp
    // to a dout_w-bit signed range. Wide internal math keeps it width-agnostic.
    function automatic logic signed [63:0] round_sat(
        input logic signed [127:0] acc,
        input int                  s,
        input int                  dout_w,
        input bit                  rnd
    );
        logic signed [127:0] v;
        logic signed [127:0] max_v;
        logic signed [127:0] min_v;
        v = acc;
        if (rnd && (s > 0)) begin
            v = v + (128'sd1 <<< (s - 1));
        end
        v     = v >>> s;
        max_v = (128'sd1 <<< (dout_w - 1)) - 128'sd1;
        min_v = -(128'sd1 <<< (dout_w - 1));
        if (v > max_v) begin
            v = max_v;
        end else if (v < min_v) begin
            v = min_v;
        end
        return v[63:0];
    endfunction

endpackage

// File: rtl/fir_frame_engine_if.sv
// rtl/fir_frame_engine_if.sv - sample, coefficient and frame bundle for fir_frame_engine
// slave: engine side (takes samples/coefficients/frame_ready, drives fir/frame/overflow).
// master: host side, the mirror image.
interface fir_frame_engine_if #(
    parameter int TAPS   = 32,
    parameter int DIN_W  = 16,
    parameter int COEF_W = 20,
    parameter int DOUT_W = 16,
    parameter int FRAME  = 16
);
    localparam int AW = $clog2(TAPS);

    logic                    data_valid;
    logic [DIN_W-1:0]        data;
    logic                    coef_we;
    logic [AW-1:0]           coef_addr;
    logic [COEF_W-1:0]       coef_data;
    logic                    fir_valid;
    logic [DOUT_W-1:0]       fir_d;
    logic                    frame_valid;
    logic                    frame_ready;
    logic [FRAME*DOUT_W-1:0] frame_d;
    logic                    overflow;

    modport master (
        output data_valid, data, coef_we, coef_addr, coef_data, frame_ready,
        input  fir_valid, fir_d, frame_valid, frame_d, overflow
    );

    modport slave (
        input  data_valid, data, coef_we, coef_addr, coef_data, frame_ready,
        output fir_valid, fir_d, frame_valid, frame_d, overflow
    );

endinterface

// File: rtl/fir_mac_core.sv
// rtl/fir_mac_core.sv - delay line, coefficient RAM, MAC and round/saturate stages
// Ports: clk, rst (sync, active-low), data_valid/data in, coef_we/coef_addr/coef_data in,
//        fir_valid/fir_d out two edges after the sample's edge.
module fir_mac_core
    import fir_frame_pkg::*;
#(
    parameter int TAPS      = 32,
    parameter int DIN_W     = 16,
    parameter int DIN_FRAC  = 8,
    parameter int COEF_W    = 20,
    parameter int COEF_FRAC = 16,
    parameter int DOUT_W    = 16,
    parameter int DOUT_FRAC = 8,
    parameter int ROUND     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_valid,
    input  logic [DIN_W-1:0]         data,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic                     fir_valid,
    output logic [DOUT_W-1:0]        fir_d
);
    localparam int ACC = acc_w(DIN_W, COEF_W, TAPS);
    localparam int S   = scale_s(DIN_FRAC, COEF_FRAC, DOUT_FRAC);

    logic signed [DIN_W-1:0]  x [TAPS];
    logic signed [COEF_W-1:0] c [TAPS];
    logic                     x_valid;
    logic signed [ACC-1:0]    acc_sum;
    logic signed [ACC-1:0]    acc_q;
    logic                     acc_valid;

    // Operands are widened to ACC before multiplying so the sum never wraps.
    always_comb begin
        acc_sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc_sum = acc_sum + (ACC'(x[k]) * ACC'(c[k]));
        end
    end

    // x_valid marks the cycle right after a shift, so the MAC register sees
    // the newly shifted line and any coefficient written on the previous edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                x[k] <= '0;
                c[k] <= '0;
            end
            x_valid   <= 1'b0;
            acc_q     <= '0;
            acc_valid <= 1'b0;
            fir_valid <= 1'b0;
            fir_d     <= '0;
        end else begin
            if (data_valid) begin
                x[0] <= data;
                for (int k = 1; k < TAPS; k++) begin
                    x[k] <= x[k-1];
                end
            end
            if (coef_we) begin
                c[coef_addr] <= coef_data;
            end
            x_valid   <= data_valid;
            acc_q     <= acc_sum;
            acc_valid <= x_valid;
            fir_valid <= acc_valid;
            fir_d     <= DOUT_W'(round_sat(128'(acc_q), S, DOUT_W, ROUND != 0));
        end
    end

endmodule

// File: rtl/fir_frame_engine.sv
// rtl/fir_frame_engine.sv - FIR front end packing filtered samples into ping-pong frames
// Ports: clk, rst (sync, active-low), bus (fir_frame_engine_if.slave): samples and
//        coefficient writes in, fir stream, frame_valid/frame_ready/frame_d and sticky overflow out.
module fir_frame_engine
    import fir_frame_pkg::*;
#(
    parameter int TAPS      = 32,
    parameter int DIN_W     = 16,
    parameter int DIN_FRAC  = 8,
    parameter int COEF_W    = 20,
    parameter int COEF_FRAC = 16,
    parameter int DOUT_W    = 16,
    parameter int DOUT_FRAC = 8,
    parameter int FRAME     = 16,
    parameter int ROUND     = 1
) (
    input  logic               clk,
    input  logic               rst,
    fir_frame_engine_if.slave  bus
);
    localparam int IW = $clog2(FRAME);

    logic                    fir_valid;
    logic [DOUT_W-1:0]       fir_d;
    logic [DOUT_W-1:0]       bank [2][FRAME];
    logic [1:0]              full;
    logic [1:0]              full_nxt;
    logic                    wr_bank;
    logic                    rd_bank;
    logic [IW-1:0]           wr_idx;
    logic                    ovf;
    wr_state_t               state;
    wr_state_t               state_nxt;
    logic                    do_write;
    logic                    do_drop;
    logic                    wr_last;
    logic                    take;
    logic [FRAME*DOUT_W-1:0] frame_w;

    fir_mac_core #(
        .TAPS      (TAPS),
        .DIN_W     (DIN_W),
        .DIN_FRAC  (DIN_FRAC),
        .COEF_W    (COEF_W),
        .COEF_FRAC (COEF_FRAC),
        .DOUT_W    (DOUT_W),
        .DOUT_FRAC (DOUT_FRAC),
        .ROUND     (ROUND)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .data_valid (bus.data_valid),
        .data       (bus.data),
        .coef_we    (bus.coef_we),
        .coef_addr  (bus.coef_addr),
        .coef_data  (bus.coef_data),
        .fir_valid  (fir_valid),
        .fir_d      (fir_d)
    );

    // A frame may only start in a free bank; a full bank at index 0 means the
    // whole next frame is discarded, keeping every frame aligned to index 0.
    // full is the registered value, so a bank freed by this cycle's handshake
    // is not reusable until the next cycle.
    always_comb begin
        state_nxt = state;
        do_write  = 1'b0;
        do_drop   = 1'b0;
        if (fir_valid) begin
            if ((wr_idx == '0) && full[wr_bank]) begin
                do_drop   = 1'b1;
                state_nxt = DROP;
            end else begin
                do_write  = 1'b1;
                state_nxt = FILL;
            end
        end
        wr_last  = do_write && (wr_idx == IW'(FRAME - 1));
        take     = full[rd_bank] && bus.frame_ready;
        full_nxt = full;
        if (take) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= FILL;
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= '0;
            ovf     <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < FRAME; i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else begin
            state <= state_nxt;
            full  <= full_nxt;
            if (do_drop) begin
                ovf <= 1'b1;
            end
            if (do_write) begin
                bank[wr_bank][wr_idx] <= fir_d;
                if (wr_last) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + IW'(1);
                end
            end
            if (take) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    always_comb begin
        frame_w = '0;
        for (int i = 0; i < FRAME; i++) begin
            frame_w[i*DOUT_W +: DOUT_W] = bank[rd_bank][i];
        end
    end

    assign bus.fir_valid   = fir_valid;
    assign bus.fir_d       = fir_d;
    assign bus.frame_valid = full[rd_bank];
    assign bus.frame_d     = frame_w;
    assign bus.overflow    = ovf;

endmodule

// File: tb/tb_fir_frame_engine.sv
// tb/tb_fir_frame_engine.sv - directed self-checking bench for fir_frame_engine (TAPS=4)
module tb_fir_frame_engine;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fir_frame_engine_if #(.TAPS(4)) b1 ();
    fir_frame_engine_if #(.TAPS(4)) b0 ();

    fir_frame_engine #(.TAPS(4), .ROUND(1)) dut_r1 (.clk(clk), .rst(rst), .bus(b1));
    fir_frame_engine #(.TAPS(4), .ROUND(0)) dut_r0 (.clk(clk), .rst(rst), .bus(b0));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [15:0] d);
        b1.data_valid = v;
        b1.data       = d;
        b0.data_valid = v;
        b0.data       = d;
    endtask

    task automatic set_ready(input logic r);
        b1.frame_ready = r;
        b0.frame_ready = r;
    endtask

    task automatic wcoef(input int a, input logic [19:0] v);
        b1.coef_we = 1'b1; b1.coef_addr = 2'(a); b1.coef_data = v;
        b0.coef_we = 1'b1; b0.coef_addr = 2'(a); b0.coef_data = v;
        tick();
        b1.coef_we = 1'b0;
        b0.coef_we = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        set_in(1'b1, d);
        tick();
        set_in(1'b0, 16'h0000);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int            nframes;
    logic [15:0]   f1_w0, f1_w15, f2_w0, f2_w15;

    initial begin
        set_in(1'b0, 16'h0000);
        set_ready(1'b0);
        b1.coef_we = 1'b0; b1.coef_addr = '0; b1.coef_data = '0;
        b0.coef_we = 1'b0; b0.coef_addr = '0; b0.coef_data = '0;

        // reset state
        tick(); tick();
        chk("rst_fir_valid", 64'(b1.fir_valid), 64'h0);
        chk("rst_fir_d", 64'(b1.fir_d), 64'h0);
        chk("rst_frame_valid", 64'(b1.frame_valid), 64'h0);
        chk("rst_frame_d_zero", 64'(b1.frame_d != '0), 64'h0);
        chk("rst_overflow", 64'(b1.overflow), 64'h0);
        rst = 1'b1;

        // identity
        wcoef(0, 20'h10000);
        send(16'h0180);
        tick(); tick();
        chk("id_valid_a", 64'(b1.fir_valid), 64'h1);
        chk("id_a", 64'(b1.fir_d), 64'h0180);
        send(16'hFE80);
        tick(); tick();
        chk("id_valid_b", 64'(b1.fir_valid), 64'h1);
        chk("id_b", 64'(b1.fir_d), 64'hFE80);
        tick();
        chk("id_valid_gap", 64'(b1.fir_valid), 64'h0);

        // rounding, c[0] = 0.5
        wcoef(0, 20'h08000);
        send(16'h0001);
        tick(); tick();
        chk("rnd1_pos", 64'(b1.fir_d), 64'h0001);
        chk("rnd0_pos", 64'(b0.fir_d), 64'h0000);
        send(16'hFFFF);
        tick(); tick();
        chk("rnd1_neg", 64'(b1.fir_d), 64'h0000);
        chk("rnd0_neg", 64'(b0.fir_d), 64'hFFFF);

        // saturation, all taps = 1.0
        for (int k = 0; k < 4; k++) wcoef(k, 20'h10000);
        for (int k = 0; k < 4; k++) send(16'h7F00);
        tick(); tick();
        chk("sat_pos", 64'(b1.fir_d), 64'h7FFF);
        for (int k = 0; k < 4; k++) send(16'h8000);
        tick(); tick();
        chk("sat_neg", 64'(b1.fir_d), 64'h8000);

        // clean restart for framing
        rst = 1'b0; tick(); rst = 1'b1;
        wcoef(0, 20'h10000);

        // frames with consumer always ready
        set_ready(1'b1);
        nframes = 0;
        f1_w0 = '0; f1_w15 = '0; f2_w0 = '0; f2_w15 = '0;
        for (int i = 0; i < 40; i++) begin
            if (i < 32) set_in(1'b1, 16'(i + 1));
            else        set_in(1'b0, 16'h0000);
            tick();
            if (b1.frame_valid) begin
                nframes++;
                if (nframes == 1) begin
                    f1_w0 = b1.frame_d[15:0]; f1_w15 = b1.frame_d[255:240];
                end else if (nframes == 2) begin
                    f2_w0 = b1.frame_d[15:0]; f2_w15 = b1.frame_d[255:240];
                end
            end
        end
        set_in(1'b0, 16'h0000);
        chk("frm_count", 64'(nframes), 64'd2);
        chk("frm1_w0", 64'(f1_w0), 64'h0001);
        chk("frm1_w15", 64'(f1_w15), 64'h0010);
        chk("frm2_w0", 64'(f2_w0), 64'h0011);
        chk("frm2_w15", 64'(f2_w15), 64'h0020);
        chk("frm_overflow", 64'(b1.overflow), 64'h0);

        // overflow: consumer stalled for 48 samples
        set_ready(1'b0);
        for (int i = 0; i < 48; i++) send(16'(i + 1));
        for (int i = 0; i < 4; i++) tick();
        chk("ovf_flag", 64'(b1.overflow), 64'h1);
        chk("ovf_valid", 64'(b1.frame_valid), 64'h1);
        chk("ovf_f1_w0", 64'(b1.frame_d[15:0]), 64'h0001);
        chk("ovf_f1_w15", 64'(b1.frame_d[255:240]), 64'h0010);
        set_ready(1'b1);
        tick();
        chk("ovf_b2b_valid", 64'(b1.frame_valid), 64'h1);
        chk("ovf_f2_w0", 64'(b1.frame_d[15:0]), 64'h0011);
        chk("ovf_f2_w15", 64'(b1.frame_d[255:240]), 64'h0020);
        tick();
        chk("ovf_drained", 64'(b1.frame_valid), 64'h0);
        set_ready(1'b0);
        for (int i = 0; i < 16; i++) send(16'(16'h0064 + i));
        for (int i = 0; i < 4; i++) tick();
        chk("rel_valid", 64'(b1.frame_valid), 64'h1);
        chk("rel_w0", 64'(b1.frame_d[15:0]), 64'h0064);
        chk("rel_w15", 64'(b1.frame_d[255:240]), 64'h0073);
        chk("rel_sticky", 64'(b1.overflow), 64'h1);
        set_ready(1'b1); tick(); set_ready(1'b0);
        chk("rel_taken", 64'(b1.frame_valid), 64'h0);

        // reset mid-frame
        for (int i = 0; i < 7; i++) send(16'(16'h0030 + i));
        for (int i = 0; i < 3; i++) tick();
        chk("part_valid", 64'(b1.frame_valid), 64'h0);
        rst = 1'b0; tick(); rst = 1'b1;
        chk("mrst_fir_valid", 64'(b1.fir_valid), 64'h0);
        chk("mrst_fir_d", 64'(b1.fir_d), 64'h0);
        chk("mrst_frame_valid", 64'(b1.frame_valid), 64'h0);
        chk("mrst_frame_d_zero", 64'(b1.frame_d != '0), 64'h0);
        chk("mrst_overflow", 64'(b1.overflow), 64'h0);
        send(16'h0100);
        tick(); tick();
        chk("mrst_coef_valid", 64'(b1.fir_valid), 64'h1);
        chk("mrst_coef_zero", 64'(b1.fir_d), 64'h0);
        wcoef(0, 20'h10000);
        for (int i = 0; i < 15; i++) send(16'(16'h0201 + i));
        for (int i = 0; i < 4; i++) tick();
        chk("post_valid", 64'(b1.frame_valid), 64'h1);
        chk("post_w0", 64'(b1.frame_d[15:0]), 64'h0000);
        chk("post_w1", 64'(b1.frame_d[31:16]), 64'h0201);
        chk("post_w15", 64'(b1.frame_d[255:240]), 64'h020F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_frame_engine.md
# fir_frame_engine

Parametrised successor to the fixed 16-bit FIR front end of the FAS datapath. Streams signed samples through a runtime-loadable TAPS-tap FIR with selectable rounding and output saturation. Packs the filtered stream into FRAME-sample ping-pong frames for the downstream FFT stage, using a valid/ready handshake and overflow reporting. Sits between the sample input port and the FFT core.

## Interface
- TAPS, 32: filter length, 2..64.
- DIN_W, 16: input sample width, signed; DIN_FRAC, 8: its fraction bits.
- COEF_W, 20: coefficient width, signed; COEF_FRAC, 16: its fraction bits.
- DOUT_W, 16: output width, signed; DOUT_FRAC, 8: its fraction bits.
- FRAME, 16: samples per frame, power of 2, 4..64.
- ROUND, 1: 1 = round half up, 0 = truncate toward −∞.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- data_valid  in  1  input sample strobe.
- data  in  DIN_W  input sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  coefficient index; 0 = newest sample.
- coef_data  in  COEF_W  coefficient value.
- fir_valid  out  1  fir_d valid this cycle.
- fir_d  out  DOUT_W  filtered sample.
- frame_valid  out  1  frame_d holds a complete frame.
- frame_ready  in  1  consumer accepts frame.
- frame_d  out  FRAME*DOUT_W  frame; sample 0 in LSBs.
- overflow  out  1  sticky; a sample was dropped.

## Operation
- Reset (rst=0 at edge) clears all of the following to 0: delay line, coefficients, pipeline, bank full bits, write/read bank, write index, and every output.
- Delay line: on data_valid, shift data into x[0]; x[k] ← x[k−1].
- MAC: acc = Σ c[k]·x[k], width DIN_W+COEF_W+clog2(TAPS), full precision.
- Scaling: shift acc right by S = DIN_FRAC+COEF_FRAC−DOUT_FRAC (=16).
  - ROUND=1: add 2^(S−1) before the shift.
  - Then saturate to [−2^(DOUT_W−1), 2^(DOUT_W−1)−1].
- Coefficient write:
  - Effective from the next cycle's MAC stage.
  - Permitted mid-stream.
  - Takes priority over nothing; independent of data_valid.
- Framer:
  - Two banks of FRAME words; write index wr_idx.
  - Each fir_valid writes bank[wr_bank][wr_idx].
  - When wr_idx = FRAME−1: set full[wr_bank], toggle wr_bank, wr_idx←0.
- Writer states:
  - FILL: normal operation.
  - DROP: entered when a fir_valid arrives with wr_idx=0 and full[wr_bank]=1. The sample is discarded and overflow←1.
  - Returns to FILL on the first fir_valid that finds full[wr_bank]=0; that sample is written at index 0, so frames stay aligned.
- Reader:
  - frame_valid = full[rd_bank]; frame_d = bank[rd_bank].
  - On frame_valid && frame_ready: clear full[rd_bank], toggle rd_bank.
- Simultaneous events:
  - Handshake frees a bank in the same cycle the writer needs it: the write is dropped, because the freed state is seen next cycle. This is deterministic and not an error.
  - A bank completing in the same cycle as a handshake on the other bank: both take effect.
- Reset mid-frame: any partial frame is discarded; overflow clears.

## Timing
- Latency: data_valid at edge N → fir_valid at edge N+2 (MAC register, then round/saturate register).
- fir_valid is one cycle per accepted sample; there are no gaps beyond input gaps.
- frame_valid rises the cycle after the edge that registers the sample at FRAME−1.
- frame_valid remains high until the handshake; frame_d is stable while it is high.
- frame_ready is ignored while frame_valid=0.
- Back-to-back frames: frame_valid stays high across the handshake if the other bank is full.

## Structure
- Package fir_frame_pkg:
  - ACC_W and S localparam functions.
  - Saturation and rounding function.
  - Writer state enum {FILL, DROP}.
- Sub-module fir_mac_core: delay line, coefficient RAM, MAC, round and saturate.
- Framer, banks and handshake live in the top level.

## Test plan
- Identity: TAPS=4, c[0]=0x10000, others 0. Inputs 0x0180, 0xFE80 → fir_d 0x0180, 0xFE80 two cycles after each input.
- Rounding: c[0]=0x08000, input 0x0001.
  - ROUND=1 → 0x0001; ROUND=0 → 0x0000.
  - Input 0xFFFF: ROUND=1 → 0x0000; ROUND=0 → 0xFFFF.
- Saturation: all four c=0x10000, four inputs 0x7F00 → fourth output 0x7FFF. Same with 0x8000 inputs → 0x8000.
- Frames: 32 samples 0x0001..0x0020 under identity, frame_ready=1.
  - Two frames result.
  - First frame: frame_d[15:0]=0x0001, top word 0x0010.
  - overflow=0.
- Overflow: frame_ready=0 for 48 samples.
  - Banks hold frames 1 and 2; samples 33–48 are dropped; overflow=1.
  - Assert frame_ready → frame 1 (starting 0x0001), then frame 2.
  - The next frame starts at the first post-release sample.
- Reset: rst=0 for one cycle after 7 samples of a frame.
  - All outputs become 0 and coefficients are 0.
  - After reload, the next frame starts at index 0.
